// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous SRAM.
// Burst-limited round-robin grant, combinational SRAM drive, one-cycle read return.
module sram_port_arbiter #(
    parameter int WID    = 32,
    parameter int DEPTH  = 1024,
    parameter int WCOUNT = $clog2(DEPTH),
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              softreset,
    input  logic [15:0]       capacity,
    input  logic              req0,
    input  logic              we0,
    input  logic [WCOUNT-1:0] addr0,
    input  logic [WID-1:0]    wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [WCOUNT-1:0] addr1,
    input  logic [WID-1:0]    wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WID-1:0]    rdata0,
    output logic [WID-1:0]    rdata1,
    output logic              cen,
    output logic              wen,
    output logic [WCOUNT-1:0] addr,
    output logic [WID-1:0]    wdata,
    input  logic [WID-1:0]    rdata,
    output logic              panic
);

    localparam logic [3:0] BURST_MAX  = 4'(BURST);
    localparam logic [4:0] WAIT_LIMIT = 5'(BURST + 1);
    localparam logic [4:0] WAIT_SAT   = 5'h1f;

    logic              owner;
    logic [3:0]        run;
    logic              rpend0;
    logic              rpend1;
    logic [4:0]        wait0;
    logic [4:0]        wait1;

    logic              granted;
    logic              sel;
    logic              we_sel;
    logic [WCOUNT-1:0] addr_sel;
    logic [WID-1:0]    wdata_sel;
    logic              over_cap;

    // Grant depends only on req/owner/run, never on returning read data.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (run < BURST_MAX) begin
                gnt0 = ~owner;
                gnt1 = owner;
            end else begin
                gnt0 = owner;
                gnt1 = ~owner;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign granted   = gnt0 | gnt1;
    assign sel       = gnt1;
    assign we_sel    = sel ? we1    : we0;
    assign addr_sel  = sel ? addr1  : addr0;
    assign wdata_sel = sel ? wdata1 : wdata0;

    always_comb begin
        cen   = 1'b1;
        wen   = 1'b1;
        addr  = '0;
        wdata = '0;
        if (granted) begin
            cen   = 1'b0;
            wen   = ~we_sel;
            addr  = addr_sel;
            wdata = we_sel ? wdata_sel : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= 1'b0;
            run    <= 4'd0;
            rpend0 <= 1'b0;
            rpend1 <= 1'b0;
        end else if (softreset) begin
            owner  <= 1'b0;
            run    <= 4'd0;
            rpend0 <= 1'b0;
            rpend1 <= 1'b0;
        end else begin
            if (granted) begin
                if (sel == owner) begin
                    if (run < BURST_MAX) run <= run + 4'd1;
                end else begin
                    owner <= sel;
                    run   <= 4'd1;
                end
            end else begin
                run <= 4'd0;
            end
            rpend0 <= gnt0 & ~we0;
            rpend1 <= gnt1 & ~we1;
        end
    end

    // Starvation watchdogs: a correct round-robin never lets these pass BURST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait0 <= 5'd0;
            wait1 <= 5'd0;
        end else if (softreset) begin
            wait0 <= 5'd0;
            wait1 <= 5'd0;
        end else begin
            if (!req0 || gnt0)          wait0 <= 5'd0;
            else if (wait0 != WAIT_SAT) wait0 <= wait0 + 5'd1;
            if (!req1 || gnt1)          wait1 <= 5'd0;
            else if (wait1 != WAIT_SAT) wait1 <= wait1 + 5'd1;
        end
    end

    // A softreset in the return cycle discards the data of the read already issued.
    assign rvalid0 = rpend0 & ~softreset;
    assign rvalid1 = rpend1 & ~softreset;
    assign rdata0  = rvalid0 ? rdata : '0;
    assign rdata1  = rvalid1 ? rdata : '0;

    assign over_cap = granted && (32'(addr_sel) >= 32'(capacity));

    assign panic = over_cap
                 | (gnt0 & gnt1)
                 | (wait0 > WAIT_LIMIT)
                 | (wait1 > WAIT_LIMIT)
                 | (rpend0 & rpend1);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_sram_port_arbiter;

    localparam int WID    = 32;
    localparam int WCOUNT = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              softreset;
    logic [15:0]       capacity;
    logic              req0, we0, req1, we1;
    logic [WCOUNT-1:0] addr0, addr1;
    logic [WID-1:0]    wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [WID-1:0]    rdata0, rdata1;
    logic              cen, wen;
    logic [WCOUNT-1:0] addr;
    logic [WID-1:0]    wdata;
    logic [WID-1:0]    rdata;
    logic              panic;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WID(WID), .DEPTH(1024), .WCOUNT(WCOUNT), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .softreset(softreset), .capacity(capacity),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .cen(cen), .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata),
        .panic(panic)
    );

    // SRAM model: unwritten words read back as addr+0x100; remembers the last write.
    logic              last_wv;
    logic [WCOUNT-1:0] last_wa;
    logic [WID-1:0]    last_wd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wv <= 1'b0;
            last_wa <= '0;
            last_wd <= '0;
            rdata   <= '0;
        end else if (!cen) begin
            if (!wen) begin
                last_wv <= 1'b1;
                last_wa <= addr;
                last_wd <= wdata;
            end else begin
                rdata <= (last_wv && last_wa == addr) ? last_wd : (32'h100 + 32'(addr));
            end
        end
    end

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        softreset = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        capacity = 16'd16;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rvalid0, rvalid1, panic, gnt0, gnt1} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_held: rv0/rv1/panic/g0/g1=%b required 00000",
                     {rvalid0, rvalid1, panic, gnt0, gnt1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({cen, wen} !== 2'b11 || addr !== '0 || wdata !== '0) begin
            n_err++;
            $display("FAIL reset_sram: cen=%b wen=%b addr=%h wdata=%h required 1 1 0 0",
                     cen, wen, addr, wdata);
        end
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, panic} !== 5'b0 || rdata0 !== '0 || rdata1 !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: g0 g1 rv0 rv1 panic=%b rd0=%h rd1=%h required all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, panic}, rdata0, rdata1);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 32'hA5A5A5A5;
        @(negedge clk);
        n_cmp++;
        if ({gnt0, gnt1, cen, wen} !== 4'b1000 || addr !== 10'd5 || wdata !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL wr_cycle: g0 g1 cen wen=%b addr=%h wdata=%h required 1000 005 a5a5a5a5",
                     {gnt0, gnt1, cen, wen}, addr, wdata);
        end
        @(posedge clk); #1;
        we0 = 1'b0; wdata0 = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({gnt0, cen, wen} !== 3'b101 || wdata !== '0) begin
            n_err++;
            $display("FAIL rd_cycle: g0 cen wen=%b wdata=%h required 101 0",
                     {gnt0, cen, wen}, wdata);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A5A5A5 || rvalid1 !== 1'b0 || rdata1 !== '0) begin
            n_err++;
            $display("FAIL rd_return: rv0=%b rd0=%h rv1=%b rd1=%h required 1 a5a5a5a5 0 0",
                     rvalid0, rdata0, rvalid1, rdata1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (rvalid0 !== 1'b0 || rdata0 !== '0) begin
            n_err++;
            $display("FAIL rd_single: rv0=%b rd0=%h required 0 0", rvalid0, rdata0);
        end
    endtask

    task automatic test_burst_limit();
        logic [1:0] exp_g [10];
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd8; wdata0 = 32'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd8; wdata1 = 32'h22;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g[c] || panic !== 1'b0) begin
                n_err++;
                $display("FAIL burst_limit c%0d: g1g0=%b panic=%b required %b 0",
                         c, {gnt1, gnt0}, panic, exp_g[c]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_burst_idle();
        logic       r0 [9];
        logic       r1 [9];
        logic [1:0] exp_g [9];
        r0    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        r1    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_g = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        do_reset();
        we0 = 1'b1; addr0 = 10'd8; we1 = 1'b1; addr1 = 10'd8;
        for (int c = 0; c < 9; c++) begin
            req0 = r0[c];
            req1 = r1[c];
            @(negedge clk);
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g[c]) begin
                n_err++;
                $display("FAIL burst_idle c%0d: g1g0=%b required %b", c, {gnt1, gnt0}, exp_g[c]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_interleaved_reads();
        logic       prev_rq;
        logic [WID-1:0] exp_d;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            if (k < 4) begin
                if (k % 2 == 0) begin req1 = 1'b1; addr1 = 10'(k + 1); end
                else            begin req0 = 1'b1; addr0 = 10'(k + 1); end
            end
            @(negedge clk);
            if (k < 4) begin
                n_cmp++;
                if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || cen !== 1'b0 || wen !== 1'b1) begin
                    n_err++;
                    $display("FAIL ilv_grant k%0d: g1g0=%b cen=%b wen=%b", k, {gnt1, gnt0}, cen, wen);
                end
            end
            if (k > 0) begin
                prev_rq = ((k - 1) % 2 == 0);
                exp_d   = 32'h100 + 32'(k);
                n_cmp++;
                if (prev_rq) begin
                    if (rvalid1 !== 1'b1 || rdata1 !== exp_d || rvalid0 !== 1'b0 || rdata0 !== '0) begin
                        n_err++;
                        $display("FAIL ilv_ret k%0d: rv1=%b rd1=%h rv0=%b rd0=%h required 1 %h 0 0",
                                 k, rvalid1, rdata1, rvalid0, rdata0, exp_d);
                    end
                end else begin
                    if (rvalid0 !== 1'b1 || rdata0 !== exp_d || rvalid1 !== 1'b0 || rdata1 !== '0) begin
                        n_err++;
                        $display("FAIL ilv_ret k%0d: rv0=%b rd0=%h rv1=%b rd1=%h required 1 %h 0 0",
                                 k, rvalid0, rdata0, rvalid1, rdata1, exp_d);
                    end
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_capacity_softreset();
        do_reset();
        capacity = 16'd16;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd16;
        @(negedge clk);
        n_cmp++;
        if (gnt1 !== 1'b1 || panic !== 1'b1 || cen !== 1'b0 || addr !== 10'd16) begin
            n_err++;
            $display("FAIL cap_panic: g1=%b panic=%b cen=%b addr=%h required 1 1 0 010",
                     gnt1, panic, cen, addr);
        end
        @(posedge clk); #1;
        req1 = 1'b0; softreset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rvalid1 !== 1'b0 || rdata1 !== '0 || panic !== 1'b0) begin
            n_err++;
            $display("FAIL soft_drop: rv1=%b rd1=%h panic=%b required 0 0 0", rvalid1, rdata1, panic);
        end
        @(posedge clk); #1;
        softreset = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd8;
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd8;
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_err++;
            $display("FAIL soft_owner: g1g0=%b required 01", {gnt1, gnt0});
        end
        @(posedge clk); #1;
        idle_inputs();
        capacity = 16'd0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd0; wdata0 = 32'h5;
        @(negedge clk);
        n_cmp++;
        if (panic !== 1'b1 || cen !== 1'b0 || wen !== 1'b0) begin
            n_err++;
            $display("FAIL cap_zero: panic=%b cen=%b wen=%b required 1 0 0", panic, cen, wen);
        end
        @(posedge clk); #1;
        idle_inputs();
        capacity = 16'd16;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_limit();
        test_burst_idle();
        test_interleaved_reads();
        test_capacity_softreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM (active-low `cen`/`wen`, 1-cycle read latency) between two requesters, e.g. two single-width RAM-backed FIFOs placed on one macro. Each cycle it grants at most one requester with a burst-limited round-robin, drives the SRAM port from the winner, and routes read data back to the owner one cycle later. It sits between the FIFO RAM-side ports and the SRAM macro.

## Interface
- `WID`, 32, data width
- `DEPTH`, 1024, SRAM words
- `WCOUNT`, `$clog2(DEPTH)`, address width
- `BURST`, 4, max consecutive grants to one requester while the other waits (1..15)
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `softreset` in 1: synchronous clear, same effect as reset on state
- `capacity` in 16: usable words; accesses at addr >= capacity flag panic
- `req0`/`req1` in 1: access request, held until granted
- `we0`/`we1` in 1: 1 = write, 0 = read
- `addr0`/`addr1` in WCOUNT: word address
- `wdata0`/`wdata1` in WID: write data
- `gnt0`/`gnt1` out 1: combinational grant; the access happens in the cycle where req && gnt
- `rvalid0`/`rvalid1` out 1: read data for that requester valid this cycle
- `rdata0`/`rdata1` out WID: `rdata` when own rvalid, else 0
- `cen` out 1: SRAM chip enable, active-low
- `wen` out 1: SRAM write enable, active-low
- `addr` out WCOUNT: SRAM address
- `wdata` out WID: SRAM write data
- `rdata` in WID: SRAM read data, valid the cycle after a read
- `panic` out 1: protocol/assertion violation, combinational

## Operation
- State: `owner` (1 bit), `run` (4 bits, saturates at BURST), `rpend0`/`rpend1` (registered read-return flags).
- Grant rules:
  - Only one req: grant it.
  - Both: grant `owner` if `run < BURST`, else grant `~owner`.
  - Neither: no grant.
- Update on a grant to g: if g == owner then run <= min(run+1, BURST); else owner <= g, run <= 1.
- No grant: run <= 0, owner unchanged. An idle cycle ends a burst.
- SRAM drive while granted: cen=0; wen = !we_g; addr = addr_g; wdata = we_g ? wdata_g : 0.
- SRAM drive while idle: cen=1, wen=1, addr=0, wdata=0.
- Read return: rpend_g <= granted && !we_g. rvalid_i = rpend_i. Exactly one cycle later, unconditional. Requester cannot stall it.
- Panic terms, ORed:
  - (a) granted access with addr_g >= capacity.
  - (b) gnt0 && gnt1.
  - (c) a requester's consecutive-wait counter (5 bits, saturating, cleared on grant or when req drops) exceeds BURST+1.
  - (d) rpend0 && rpend1.
- (b) and (d) are unreachable in a correct design and are kept as assertions.

## Timing
- Reset/softreset values: owner=0, run=0, rpend0=rpend1=0, wait counters 0.
- Consequences at reset: rvalid0/1=0, rdata0/1=0, panic=0.
- With no req at reset: gnt0/1=0, cen=1, wen=1, addr=0, wdata=0.
- Grant latency: 0 cycles, combinational from req/owner/run. No combinational path from `rdata` to any gnt.
- Write: SRAM samples in the grant cycle.
- Read: rvalid_g and rdata_g valid in the cycle after the grant.
- Back-to-back reads from alternating requesters return in issue order, one per cycle.
- softreset asserted in the cycle after a read grant drops that rvalid. The SRAM access already issued completes, and its data is discarded.
- Async reset mid-burst: owner/run are lost. The next tie goes to requester 0.
- capacity=0: every granted access raises panic. The access is still performed, since panic is not a gate.

## Test plan
- **Reset idle:** hold rst_n=0, then release with no req. Required: cen=1, wen=1, addr=0, all gnt/rvalid/panic=0.
- **Single writer then reader:** req0 write addr=5 wdata=0xA5A5A5A5, then req0 read addr=5. Required: gnt0 both cycles; cen=0, wen=0 on the write; one cycle after the read, rvalid0=1 and rdata0=0xA5A5A5A5, rdata1=0.
- **Burst limit, BURST=4:** req0 and req1 held high from reset for 10 cycles. Required grant sequence 0,0,0,0,1,1,1,1,0,0. panic stays 0.
- **Burst broken by idle:** req0 for 2 cycles, one idle cycle, then both req for 6 cycles. Required grants 0,0,-,0,0,0,0,1,1. run restarts at 1 after the idle.
- **Interleaved reads:** alternate granted reads 1,0,1,0 to addresses 1,2,3,4, with the SRAM model returning addr+0x100. Required: rvalid1/rvalid0 alternate one cycle later with 0x101, 0x102, 0x103, 0x104, never both high.
- **Capacity/softreset:** capacity=16, req1 read addr=16. Required: panic=1 that cycle. Assert softreset the next cycle. Required: rvalid1=0 and run/owner cleared.
